// File: rtl/lti_sample_sequencer.sv
// Sample-strobe driver for the state-space filter: paces input samples at a
// programmable period, collects the returned result and saturates it downstream.
module lti_sample_sequencer #(
  parameter int IW  = 16,
  parameter int OW  = 20,
  parameter int DW  = 16,
  parameter int PW  = 16,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] period,
  input  logic          clr,
  input  logic [IW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          ce_in,
  output logic [IW-1:0] sig_in_1,
  input  logic          ce_out,
  input  logic [OW-1:0] sig_out_1,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          underrun,
  output logic          overrun,
  output logic          timeout,
  output logic          sat,
  output logic [7:0]    drop_cnt
);
  localparam int TW = $clog2(TMO + 1);
  localparam logic signed [OW-1:0] MAXV = {{(OW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [OW-1:0] MINV = {{(OW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, WAIT_RET} state_t;
  state_t state, state_n;

  logic [PW-1:0] cnt, eff_m1;
  logic [TW-1:0] tmo_cnt;
  logic          tick, latch, und_set, ovr_set, tmo_set, capture;
  logic          hi, lo;
  logic [DW-1:0] sat_val;

  // >= rather than == so a period shrunk mid-run wraps at once instead of
  // running the counter all the way around.
  assign eff_m1 = (period < PW'(8)) ? PW'(7) : period - PW'(1);
  assign tick   = enable && (cnt >= eff_m1);
  assign ce_in  = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst || !enable) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + PW'(1);
  end

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    latch   = 1'b0;
    und_set = 1'b0;
    ovr_set = 1'b0;
    tmo_set = 1'b0;
    capture = 1'b0;
    if (!enable) state_n = IDLE;
    else begin
      case (state)
        IDLE:      state_n = WAIT_TICK;
        WAIT_TICK: if (tick) begin
          s_ready = s_valid;
          latch   = s_valid;
          und_set = !s_valid;
          state_n = ISSUE;
        end
        ISSUE: begin
          ovr_set = tick;
          state_n = WAIT_RET;
        end
        WAIT_RET: begin
          ovr_set = tick;
          if (ce_out) begin
            capture = 1'b1;
            state_n = WAIT_TICK;
          end else if (tmo_cnt <= TW'(1)) begin
            tmo_set = 1'b1;
            state_n = WAIT_TICK;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign hi      = $signed(sig_out_1) > MAXV;
  assign lo      = $signed(sig_out_1) < MINV;
  assign sat_val = hi ? {1'b0, {(DW-1){1'b1}}} :
                   lo ? {1'b1, {(DW-1){1'b0}}} : sig_out_1[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      sig_in_1 <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      sat      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == ISSUE)         tmo_cnt <= TW'(TMO);
      else if (state == WAIT_RET) tmo_cnt <= tmo_cnt - TW'(1);
      if (latch) sig_in_1 <= s_data;
      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= sat_val;
      end else if (m_ready) m_valid <= 1'b0;
      if (clr) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
        timeout  <= 1'b0;
        sat      <= 1'b0;
        drop_cnt <= '0;
      end else begin
        underrun <= underrun | und_set;
        overrun  <= overrun | ovr_set;
        timeout  <= timeout | tmo_set;
        sat      <= sat | (capture & (hi | lo));
        if (capture && m_valid && !m_ready && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_lti_sample_sequencer.sv
// Randomized bench: a cycle-indexed transaction model (tick times, issue and
// return windows) predicts every output of the sequencer each cycle.
module tb_lti_sample_sequencer;
  localparam int IW = 16, OW = 20, DW = 16, PW = 16, TMO = 64;
  localparam int F_ECHO = 0, F_NONE = 1, F_SAT = 2, F_RLAT = 3;

  logic clk = 1'b0;
  logic rst, enable, clr, s_valid, s_ready, ce_in, ce_out, m_valid, m_ready;
  logic underrun, overrun, timeout, sat;
  logic [PW-1:0] period;
  logic [IW-1:0] s_data, sig_in_1;
  logic [OW-1:0] sig_out_1;
  logic [DW-1:0] m_data;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  lti_sample_sequencer #(.IW(IW), .OW(OW), .DW(DW), .PW(PW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ce_in(ce_in), .sig_in_1(sig_in_1), .ce_out(ce_out), .sig_out_1(sig_out_1),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .underrun(underrun), .overrun(overrun), .timeout(timeout), .sat(sat),
    .drop_cnt(drop_cnt)
  );

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // model: registered outputs plus transaction timestamps
  logic [IW-1:0] e_sig;
  logic [DW-1:0] e_mdata;
  bit  e_mval, e_und, e_ovr, e_tmo, e_sat;
  int  e_drop;
  int  run_len, iss_at, out_at;
  bit  prev_live;
  logic [OW-1:0] ret_val[int];

  // phase knobs
  int fmode, sv_pct, mr_pct, clr_pct, en_pct, rst_pct, spur_pct, sat_k;
  bit seq_inc;
  logic [IW-1:0] seq;

  function automatic logic [DW-1:0] clip_to_dw(input logic [OW-1:0] v, output bit clipped);
    longint x, mx, mn;
    x  = longint'($signed(v));
    mx = (longint'(1) << (DW-1)) - 1;
    mn = -(longint'(1) << (DW-1));
    clipped = (x > mx) || (x < mn);
    if (x > mx) x = mx;
    if (x < mn) x = mn;
    return DW'(x);
  endfunction

  task automatic model_reset();
    e_sig = '0; e_mdata = '0; e_mval = 0; e_und = 0; e_ovr = 0; e_tmo = 0;
    e_sat = 0; e_drop = 0; run_len = 0; iss_at = -1; out_at = -1; prev_live = 0;
  endtask

  task automatic one_cycle(input int i);
    int eff, l;
    bit tick, wt, exp_sr, cap, clip, und_s, ovr_s, tmo_s;
    logic [DW-1:0] cv;
    logic [OW-1:0] fv;
    // drive this cycle's inputs
    rst     = ($urandom_range(99) < rst_pct);
    if (i == 0)      enable = 1'b0;
    else if (i == 1) enable = 1'b1;
    else if ($urandom_range(99) < en_pct) enable = ~enable;
    clr     = (i == 0) || ($urandom_range(99) < clr_pct);
    s_valid = ($urandom_range(99) < sv_pct);
    m_ready = ($urandom_range(99) < mr_pct);
    s_data  = seq;
    if (ret_val.exists(cyc)) begin
      ce_out = 1'b1; sig_out_1 = ret_val[cyc]; ret_val.delete(cyc);
    end else begin
      ce_out = ($urandom_range(99) < spur_pct);
      sig_out_1 = OW'($urandom);
    end
    #1;
    eff    = (int'(period) < 8) ? 8 : int'(period);
    tick   = enable && (run_len % eff == eff - 1);
    wt     = prev_live && (iss_at != cyc) && (out_at < 0);
    exp_sr = wt && tick && s_valid;
    chk("ce_in",    ce_in,    (iss_at == cyc));
    chk("s_ready",  s_ready,  exp_sr);
    chk("sig_in_1", sig_in_1, e_sig);
    chk("m_valid",  m_valid,  e_mval);
    chk("m_data",   m_data,   e_mdata);
    chk("underrun", underrun, e_und);
    chk("overrun",  overrun,  e_ovr);
    chk("timeout",  timeout,  e_tmo);
    chk("sat",      sat,      e_sat);
    chk("drop_cnt", drop_cnt, e_drop);
    // filter stand-in answers the observed strobe
    if (ce_in && fmode != F_NONE) begin
      l = (fmode == F_RLAT) ? $urandom_range(1, 80) : 4;
      if (fmode == F_SAT) begin
        case (sat_k % 3)
          0:       fv = 20'h3FFFF;
          1:       fv = 20'hC0000;
          default: fv = OW'($urandom);
        endcase
        sat_k++;
      end else fv = OW'(sig_in_1) << 4;
      ret_val[cyc + l] = fv;
    end
    // advance the model across the clock edge
    if (rst) model_reset();
    else begin
      cap = 0; und_s = 0; ovr_s = 0; tmo_s = 0; clip = 0; cv = '0;
      if (!enable) begin
        iss_at = -1; out_at = -1;
      end else if (iss_at == cyc) begin
        ovr_s = tick; out_at = cyc; iss_at = -1;
      end else if (out_at >= 0) begin
        ovr_s = tick;
        if (ce_out) begin
          cap = 1; out_at = -1;
        end else if (cyc == out_at + TMO) begin
          tmo_s = 1; out_at = -1;
        end
      end else if (prev_live && tick) begin
        if (s_valid) e_sig = s_data; else und_s = 1;
        iss_at = cyc + 1;
      end
      if (cap) begin
        cv = clip_to_dw(sig_out_1, clip);
        if (e_mval && !m_ready && e_drop < 255) e_drop++;
        e_mval = 1; e_mdata = cv;
      end else if (m_ready) e_mval = 0;
      e_und |= und_s; e_ovr |= ovr_s; e_tmo |= tmo_s; e_sat |= (cap && clip);
      if (clr) begin
        e_und = 0; e_ovr = 0; e_tmo = 0; e_sat = 0; e_drop = 0;
      end
      run_len   = enable ? run_len + 1 : 0;
      prev_live = enable;
      if (exp_sr) seq = seq_inc ? seq + IW'(1) : IW'($urandom);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_phase(input int n, input int per, input int fm, input int sv,
                           input int mr, input int cl, input int en, input int rs,
                           input int sp);
    period = PW'(per); fmode = fm; sv_pct = sv; mr_pct = mr; clr_pct = cl;
    en_pct = en; rst_pct = rs; spur_pct = sp;
    for (int i = 0; i < n; i++) one_cycle(i);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    period = PW'(10); s_data = '0; ce_out = 1'b0; sig_out_1 = '0;
    seq = IW'(1); seq_inc = 1; sat_k = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_in", ce_in, 0);       chk("rst_s_ready", s_ready, 0);
    chk("rst_sig_in", sig_in_1, 0);   chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);     chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);   chk("rst_timeout", timeout, 0);
    chk("rst_sat", sat, 0);           chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // period 10, samples 1,2,3... echoed <<4 with 4-cycle latency
    run_phase(60, 10, F_ECHO, 100, 100, 0, 0, 0, 0);
    chk("p_no_underrun", underrun, 0);
    chk("p_no_overrun", overrun, 0);
    chk("p_no_timeout", timeout, 0);
    seq_inc = 0;
    run_phase(120, 12, F_ECHO, 50, 100, 0, 0, 0, 0);
    run_phase(240, 8, F_SAT, 100, 100, 0, 0, 0, 0);
    chk("sat_seen", sat, 1);
    run_phase(300, 8, F_NONE, 100, 100, 0, 0, 0, 0);
    chk("tmo_seen", timeout, 1);
    chk("tmo_ovr_seen", overrun, 1);
    run_phase(800, $urandom_range(0, 20), F_ECHO, 70, 60, 2, 1, 1, 3);
    run_phase(800, $urandom_range(8, 40), F_RLAT, 80, 50, 1, 1, 1, 2);
    run_phase(2200, 8, F_ECHO, 100, 0, 0, 0, 0, 0);
    chk("drop_saturated", drop_cnt, 255);
    run_phase(80, 9, F_ECHO, 100, 100, 0, 0, 0, 0);
    chk("drop_cleared", drop_cnt, 0);
    run_phase(600, $urandom_range(0, 16), F_RLAT, 70, 50, 3, 3, 2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
